// File: rtl/dmem_responder.sv
// Data-memory responder: posted-write buffer with store-to-load forwarding in
// front of a single-ported SRAM. Loads take priority over draining the buffer.
module dmem_responder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  input  logic                     req_we,
  input  logic                     req_re,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_valid,
  output logic                     stall,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  output logic                     mem_we,
  output logic                     mem_re,
  input  logic                     mem_gnt,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_rvalid,
  output logic [$clog2(DEPTH):0]   wb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_REQ  = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;

  logic [1:0]        r_state;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_valid;
  logic              r_fill_done;

  logic [ADDR_W-1:0] r_buf_addr [DEPTH];
  logic [31:0]       r_buf_data [DEPTH];

  logic [ADDR_W-1:0] w_req_addr;
  logic              w_unused_addr;
  logic              w_idle;
  logic              w_full;
  logic              w_empty;
  logic              w_load;
  logic              w_push;
  logic              w_pop;
  logic              w_hit;
  logic [31:0]       w_hit_data;
  logic              w_hit_rsp;
  logic              w_miss;
  logic              w_fill;

  assign w_req_addr    = req_addr[ADDR_W-1:0];
  assign w_unused_addr = ^req_addr[31:ADDR_W];

  assign w_idle  = (r_state == S_IDLE);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_load  = req_re & ~req_we;

  // Scan oldest to youngest so the last live match (the youngest) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    w_hit      = 1'b0;
    w_hit_data = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (r_buf_addr[idx] == w_req_addr)) begin
        w_hit      = 1'b1;
        w_hit_data = r_buf_data[idx];
      end
    end
  end

  // The cycle after a fill, the core still presents the load just answered.
  assign w_hit_rsp = w_idle & w_load & w_hit & ~r_fill_done;
  assign w_miss    = w_idle & w_load & ~w_hit & ~r_fill_done;
  assign w_fill    = (r_state == S_RD_WAIT) & mem_rvalid;

  assign w_push = w_idle & req_we & ~w_full;
  assign mem_we = w_idle & ~w_empty;
  assign mem_re = (r_state == S_RD_REQ);
  assign w_pop  = mem_we & mem_gnt;

  assign stall = reset & ((req_we & w_full) | w_miss | ~w_idle);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_re) begin
      mem_addr = w_req_addr;
    end else if (mem_we) begin
      mem_addr  = r_buf_addr[r_head];
      mem_wdata = r_buf_data[r_head];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_addr[r_tail] <= w_req_addr;
      r_buf_data[r_tail] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_valid <= 1'b0;
      r_fill_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:    if (w_miss)     r_state <= S_RD_REQ;
        S_RD_REQ:  if (mem_gnt)    r_state <= S_RD_WAIT;
        S_RD_WAIT: if (mem_rvalid) r_state <= S_IDLE;
        default:                   r_state <= S_IDLE;
      endcase

      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      r_fill_done <= w_fill;
      r_rsp_valid <= w_hit_rsp | w_fill;
      if (w_fill) begin
        r_rsp_rdata <= mem_rdata;
      end else if (w_hit_rsp) begin
        r_rsp_rdata <= w_hit_data;
      end
    end
  end

  assign rsp_rdata = r_rsp_rdata;
  assign rsp_valid = r_rsp_valid;
  assign wb_count  = r_count;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a core driver, an SRAM model and a program-order memory
// model that every load is compared against.
module tb_dmem_responder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [31:0]       req_addr = '0, req_wdata = '0;
  logic              req_we = 1'b0, req_re = 1'b0;
  logic [31:0]       rsp_rdata;
  logic              rsp_valid, stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we, mem_re;
  logic              mem_gnt, mem_rvalid;
  logic [31:0]       mem_rdata;
  logic [$clog2(DEPTH):0] wb_count;

  // SRAM side: either a random-latency model or pins driven by a directed test
  bit          manual = 1'b0;
  int          gnt_pct = 100;
  logic        man_gnt = 1'b0, man_rvalid = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        auto_gnt = 1'b0, auto_rvalid = 1'b0;
  logic [31:0] auto_rdata = '0;
  bit          rd_pending = 1'b0;
  int          rd_cnt = 0;
  logic [9:0]  rd_addr = '0;

  assign mem_gnt    = manual ? man_gnt    : auto_gnt;
  assign mem_rvalid = manual ? man_rvalid : auto_rvalid;
  assign mem_rdata  = manual ? man_rdata  : auto_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_re(req_re),
    .rsp_rdata(rsp_rdata), .rsp_valid(rsp_valid), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .wb_count(wb_count)
  );

  typedef struct packed { logic [9:0] a; logic [31:0] d; } wr_t;
  wr_t         wq[$];        // stores accepted by the core, not yet written to SRAM
  logic [31:0] exp_q[$];     // load results in issue order
  logic [31:0] sram    [1024];
  logic [31:0] ref_mem [1024];  // memory as the program sees it
  int          re_seen = 0;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Cycle monitor: SRAM-port rules, write-drain order, occupancy and responses
  always @(negedge clk) begin
    if (reset) begin
      check_eq("mem_exclusive", 32'(mem_we & mem_re), 32'd0);
      if (!mem_we && !mem_re) begin
        check_eq("mem_addr_idle", 32'(mem_addr), 32'd0);
        check_eq("mem_wdata_idle", mem_wdata, 32'd0);
      end
      if (mem_we) begin
        if (wq.size() == 0) check_eq("drain_when_empty", 32'd1, 32'd0);
        else begin
          check_eq("drain_addr", 32'(mem_addr), 32'(wq[0].a));
          check_eq("drain_data", mem_wdata, wq[0].d);
        end
      end
      check_eq("wb_count", 32'(wb_count), 32'(wq.size()));
      if (mem_re) re_seen++;
      if (rsp_valid) begin
        if (exp_q.size() == 0) check_eq("rsp_spurious", 32'd1, 32'd0);
        else check_eq("rsp_rdata", rsp_rdata, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    auto_rvalid = 1'b0;
    if (rd_pending) begin
      if (rd_cnt == 0) begin
        auto_rvalid = 1'b1;
        auto_rdata  = sram[rd_addr];
        rd_pending  = 1'b0;
      end else rd_cnt--;
    end
    auto_gnt = (mem_we | mem_re) && ($urandom_range(0, 99) < gnt_pct);
  end

  always @(posedge clk) begin
    if (reset) begin
      if (mem_we && mem_gnt) begin
        sram[mem_addr] = mem_wdata;
        if (wq.size() > 0) void'(wq.pop_front());
      end
      if (!manual && mem_re && mem_gnt) begin
        rd_pending = 1'b1;
        rd_addr    = mem_addr;
        rd_cnt     = $urandom_range(0, 2);
      end
    end
  end

  // Core driver: hold the request while stalled, retire it on the first unstalled edge
  task automatic issue(input bit we, input bit re, input logic [31:0] addr,
                       input logic [31:0] data, output int stalls);
    logic [9:0] a;
    bit exp_hit;
    a = addr[9:0];
    exp_hit = 1'b0;
    foreach (wq[i]) if (wq[i].a == a) exp_hit = 1'b1;
    if (re && !we) exp_q.push_back(ref_mem[a]);
    req_addr = addr; req_wdata = data; req_we = we; req_re = re;
    stalls = 0;
    while (1) begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
      if (stalls > 300) begin
        check_eq("stall_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    if (we) begin
      wq.push_back('{a: a, d: data});
      ref_mem[a] = data;
    end
    #1;
    req_we = 1'b0; req_re = 1'b0;
    if (re && !we && exp_hit) check_eq("hit_no_stall", 32'(stalls), 32'd0);
  endtask

  task automatic wait_drain();
    int n;
    manual = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0; gnt_pct = 100;
    n = 0;
    while ((wb_count != 0 || rd_pending) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_done", 32'(wb_count), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, mism, op;
    logic [9:0] a;
    for (int i = 0; i < 1024; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end

    // reset state, with a load presented so stall has a reason to rise
    req_re = 1'b1;
    #12;
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_re", 32'(mem_re), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_wb_count", 32'(wb_count), 32'd0);
    req_re = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // store forwarded to a load with the SRAM refusing everything
    manual = 1'b1; man_gnt = 1'b0; re_seen = 0;
    issue(1, 0, 32'd5, 32'hDEADBEEF, st);
    issue(0, 1, 32'd5, 32'd0, st);
    @(negedge clk);
    check_eq("fwd_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("fwd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    check_eq("fwd_no_mem_re", 32'(re_seen), 32'd0);
    @(posedge clk); #1;

    // youngest of two matching entries wins
    issue(1, 0, 32'd7, 32'd1, st);
    issue(1, 0, 32'd7, 32'd2, st);
    issue(0, 1, 32'd7, 32'd0, st);
    @(negedge clk);
    check_eq("youngest_wins", rsp_rdata, 32'd2);
    @(posedge clk); #1;
    wait_drain();

    // fill the buffer, stall a fifth store, free one slot with a single grant
    manual = 1'b1; man_gnt = 1'b0;
    for (int i = 0; i < 4; i++) issue(1, 0, 32'(16 + i), 32'(32'h100 + i), st);
    @(negedge clk);
    check_eq("wb_full", 32'(wb_count), 32'd4);
    @(posedge clk); #1;
    fork
      issue(1, 0, 32'd20, 32'h104, st);
      begin
        @(negedge clk);
        check_eq("stall_when_full", 32'(stall), 32'd1);
        check_eq("fifo_head", 32'(mem_addr), 32'd16);
        man_gnt = 1'b1;
        @(negedge clk);
        man_gnt = 1'b0;
      end
    join
    check_eq("fifth_store_stalls", 32'(st), 32'd1);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check_eq("fifo_order", 32'(mem_addr), 32'(16 + i));
      man_gnt = 1'b1;
      @(posedge clk); #1;
      man_gnt = 1'b0;
    end
    wait_drain();

    // load miss: grant on the 2nd request cycle, data 3 cycles after the grant
    manual = 1'b1; man_gnt = 1'b0;
    issue(1, 0, 32'd40, 32'hA0, st);
    issue(1, 0, 32'd41, 32'hA1, st);
    sram[10'h3FF] = 32'h12345678;
    ref_mem[10'h3FF] = 32'h12345678;
    fork
      issue(0, 1, 32'hFFFF_F3FF, 32'd0, st);
      begin
        @(negedge clk);
        check_eq("miss_stall_c1", 32'(stall), 32'd1);
        for (int c = 2; c <= 6; c++) begin
          @(negedge clk);
          check_eq("miss_stall", 32'(stall), 32'd1);
          check_eq("miss_no_mem_we", 32'(mem_we), 32'd0);
          if (c <= 3) begin
            check_eq("miss_mem_re", 32'(mem_re), 32'd1);
            check_eq("miss_mem_addr", 32'(mem_addr), 32'h3FF);
          end
          man_gnt = (c == 3);
          if (c == 6) begin
            man_rvalid = 1'b1;
            man_rdata  = 32'h12345678;
          end
        end
        @(negedge clk);
        man_rvalid = 1'b0;
        check_eq("miss_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("miss_rsp_rdata", rsp_rdata, 32'h12345678);
        check_eq("miss_stall_released", 32'(stall), 32'd0);
      end
    join
    check_eq("miss_stall_cycles", 32'(st), 32'd6);
    wait_drain();

    // store and load together count as a store
    manual = 1'b1; man_gnt = 1'b0;
    issue(1, 1, 32'd9, 32'hA5, st);
    @(negedge clk);
    check_eq("we_re_is_store", 32'(wb_count), 32'd1);
    check_eq("we_re_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    issue(0, 1, 32'd9, 32'd0, st);
    @(negedge clk);
    check_eq("we_re_readback", rsp_rdata, 32'hA5);
    @(posedge clk); #1;
    wait_drain();

    // random traffic against the program-order model
    gnt_pct = 40;
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      a  = (($urandom_range(0, 15) == 0) ? 10'h3FF : 10'($urandom_range(0, 15)));
      if (op < 5)      issue(1, 0, ($urandom & 32'hFFFF_FC00) | 32'(a), $urandom, st);
      else if (op < 9) issue(0, 1, ($urandom & 32'hFFFF_FC00) | 32'(a), 32'd0, st);
      else             issue(1, 1, 32'(a), $urandom, st);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_drain();

    // reset during an outstanding read with three posted writes
    manual = 1'b1; man_gnt = 1'b0;
    for (int i = 0; i < 3; i++) issue(1, 0, 32'(50 + i), 32'(32'h500 + i), st);
    req_addr = 32'd100; req_re = 1'b1;
    @(negedge clk);
    @(negedge clk); man_gnt = 1'b1;
    @(negedge clk); man_gnt = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("rst_mid_wb_count", 32'(wb_count), 32'd0);
    check_eq("rst_mid_stall", 32'(stall), 32'd0);
    check_eq("rst_mid_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mid_mem_re", 32'(mem_re), 32'd0);
    check_eq("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mid_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
    req_re = 1'b0;
    wq.delete();
    exp_q.delete();
    for (int i = 0; i < 1024; i++) ref_mem[i] = sram[i];
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); man_rvalid = 1'b1; man_rdata = 32'hBAD0BAD0;
    @(negedge clk); man_rvalid = 1'b0;
    check_eq("late_rvalid_ignored", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("late_rvalid_ignored2", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // operation resumes normally
    manual = 1'b0; gnt_pct = 50;
    issue(1, 0, 32'd33, 32'hC0FFEE00, st);
    issue(0, 1, 32'd33, 32'd0, st);
    issue(0, 1, 32'd100, 32'd0, st);
    wait_drain();
    repeat (2) @(negedge clk);

    mism = 0;
    for (int i = 0; i < 1024; i++) if (sram[i] !== ref_mem[i]) mism++;
    check_eq("sram_final", 32'(mism), 32'd0);
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
